// File: rtl/adc_sample_fifo.sv
// Captures one SPI ADC word per FIN rising edge into a first-word-fall-through FIFO drained by valid/ready.
// Tracks samples per burst, flags the final sample of a burst and counts words lost to overflow.
module adc_sample_fifo #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 4,
   parameter int BURST_LEN  = 1024
) (
   input  logic              SYS_CLK,
   input  logic              RST,
   input  logic              ON,
   input  logic              FIN,
   input  logic [DATA_W-1:0] DATA_MISO,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_LAST,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              FULL,
   output logic [15:0]       SAMPLE_COUNT,
   output logic [7:0]        DROP_COUNT,
   output logic              BURST_DONE
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W:0]       r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_occ;
   logic                  r_fin_q;
   logic [15:0]           r_sample_count;
   logic [7:0]            r_drop_count;

   logic                  w_fin_rise;
   logic                  w_cap;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_last;
   logic [DATA_W:0]       w_head;

   assign w_fin_rise = FIN & ~r_fin_q;
   assign w_cap      = w_fin_rise & ON & ~BURST_DONE;
   assign w_pop      = OUT_VALID & OUT_READY;
   // A full FIFO still accepts a write when the head is leaving on the same edge.
   assign w_push     = w_cap & (~FULL | w_pop);
   assign w_drop     = w_cap & FULL & ~w_pop;
   assign w_last     = (r_sample_count == 16'(BURST_LEN - 1));
   assign w_head     = r_mem[r_rd_ptr];

   assign OUT_VALID    = (r_occ != '0);
   assign FULL         = (r_occ == (DEPTH_LOG2+1)'(DEPTH));
   assign OUT_DATA     = OUT_VALID ? w_head[DATA_W-1:0] : '0;
   assign OUT_LAST     = OUT_VALID & w_head[DATA_W];
   assign SAMPLE_COUNT = r_sample_count;
   assign DROP_COUNT   = r_drop_count;
   assign BURST_DONE   = (r_sample_count == 16'(BURST_LEN));

   always_ff @(posedge SYS_CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {w_last, DATA_MISO};
      end
   end

   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_fin_q  <= 1'b0;
      end else begin
         r_fin_q <= FIN;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + (DEPTH_LOG2+1)'(1);
            2'b01:   r_occ <= r_occ - (DEPTH_LOG2+1)'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Burst length counts conversions, so dropped words still advance the sample count.
   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         r_sample_count <= '0;
         r_drop_count   <= '0;
      end else begin
         if (!ON) begin
            r_sample_count <= '0;
         end else if (w_cap) begin
            r_sample_count <= r_sample_count + 16'd1;
         end
         if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo: default instance plus a BURST_LEN=4 instance for burst framing.
module tb_adc_sample_fifo;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        on = 1'b0;
   logic        b_on = 1'b0;
   logic        fin = 1'b0;
   logic [15:0] data_miso = '0;
   logic        ready = 1'b0;
   logic        b_ready = 1'b0;

   logic [15:0] out_data, b_out_data;
   logic        out_last, b_out_last;
   logic        out_valid, b_out_valid;
   logic        full, b_full;
   logic [15:0] sample_count, b_sample_count;
   logic [7:0]  drop_count, b_drop_count;
   logic        burst_done, b_burst_done;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   adc_sample_fifo dut (
      .SYS_CLK(sys_clk), .RST(rst), .ON(on), .FIN(fin), .DATA_MISO(data_miso),
      .OUT_DATA(out_data), .OUT_LAST(out_last), .OUT_VALID(out_valid), .OUT_READY(ready),
      .FULL(full), .SAMPLE_COUNT(sample_count), .DROP_COUNT(drop_count), .BURST_DONE(burst_done)
   );

   adc_sample_fifo #(.BURST_LEN(4)) dut_b (
      .SYS_CLK(sys_clk), .RST(rst), .ON(b_on), .FIN(fin), .DATA_MISO(data_miso),
      .OUT_DATA(b_out_data), .OUT_LAST(b_out_last), .OUT_VALID(b_out_valid), .OUT_READY(b_ready),
      .FULL(b_full), .SAMPLE_COUNT(b_sample_count), .DROP_COUNT(b_drop_count), .BURST_DONE(b_burst_done)
   );

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic pulse(input logic [15:0] d);
      data_miso = d;
      fin = 1'b1;
      tick();
      fin = 1'b0;
      tick();
   endtask

   task automatic rearm();
      on = 1'b0;
      tick();
      on = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({out_valid, full, burst_done, out_last, out_data, sample_count, drop_count} !== 36'h0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b f=%b bd=%b l=%b d=%h sc=%0d dc=%0d, expected all zero",
                  out_valid, full, burst_done, out_last, out_data, sample_count, drop_count);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [15:0] v [3];
      v[0] = 16'h1234; v[1] = 16'h5678; v[2] = 16'h9ABC;
      on = 1'b1;
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_miso = v[i];
         fin = 1'b1;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== v[i]) begin
            errors++;
            $display("FAIL basic_word%0d: got v=%b d=%h, expected v=1 d=%h", i, out_valid, out_data, v[i]);
         end
         fin = 1'b0;
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop%0d: got v=%b, expected 0", i, out_valid);
         end
      end
      checks++;
      if (sample_count !== 16'd3) begin
         errors++;
         $display("FAIL basic_count: got %0d, expected 3", sample_count);
      end
   endtask

   task automatic test_overflow();
      ready = 1'b0;
      rearm();
      for (int i = 0; i < 20; i++) begin
         pulse(16'hA000 + 16'(i));
         if (i == 14 || i == 15) begin
            checks++;
            if (full !== (i == 15)) begin
               errors++;
               $display("FAIL ovf_full_after_%0d: got %b, expected %b", i + 1, full, (i == 15));
            end
         end
      end
      checks++;
      if (drop_count !== 8'd4 || sample_count !== 16'd20) begin
         errors++;
         $display("FAIL ovf_counts: got drop=%0d sc=%0d, expected drop=4 sc=20", drop_count, sample_count);
      end
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'hA000 + 16'(i)) begin
            errors++;
            $display("FAIL ovf_drain%0d: got v=%b d=%h, expected v=1 d=%h", i, out_valid, out_data, 16'hA000 + 16'(i));
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_empty: got v=%b, expected 0", out_valid);
      end
      ready = 1'b0;
   endtask

   task automatic test_burst();
      on = 1'b0;
      b_on = 1'b1;
      b_ready = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) pulse(16'hD000 + 16'(i));
      checks++;
      if (b_sample_count !== 16'd4 || b_burst_done !== 1'b1 || b_drop_count !== 8'd0) begin
         errors++;
         $display("FAIL burst_state: got sc=%0d bd=%b dc=%0d, expected sc=4 bd=1 dc=0",
                  b_sample_count, b_burst_done, b_drop_count);
      end
      b_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (b_out_valid !== 1'b1 || b_out_data !== 16'hD000 + 16'(i) || b_out_last !== (i == 3)) begin
            errors++;
            $display("FAIL burst_word%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                     i, b_out_valid, b_out_data, b_out_last, 16'hD000 + 16'(i), (i == 3));
         end
         tick();
      end
      checks++;
      if (b_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL burst_only4: got v=%b, expected 0", b_out_valid);
      end
      b_ready = 1'b0;
      b_on = 1'b0;
      tick();
      checks++;
      if (b_sample_count !== 16'd0 || b_burst_done !== 1'b0) begin
         errors++;
         $display("FAIL burst_clear: got sc=%0d bd=%b, expected sc=0 bd=0", b_sample_count, b_burst_done);
      end
      b_on = 1'b1;
      pulse(16'hE000);
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== 16'hE000 || b_out_last !== 1'b0 || b_sample_count !== 16'd1) begin
         errors++;
         $display("FAIL burst_rearm: got v=%b d=%h l=%b sc=%0d, expected v=1 d=e000 l=0 sc=1",
                  b_out_valid, b_out_data, b_out_last, b_sample_count);
      end
      b_on = 1'b0;
   endtask

   task automatic test_full_push_pop();
      ready = 1'b0;
      rearm();
      for (int i = 0; i < 16; i++) pulse(16'hB000 + 16'(i));
      data_miso = 16'hC0DE;
      fin = 1'b1;
      ready = 1'b1;
      tick();
      fin = 1'b0;
      ready = 1'b0;
      checks++;
      if (full !== 1'b1 || drop_count !== 8'd4 || out_data !== 16'hB001) begin
         errors++;
         $display("FAIL fullpp_state: got full=%b dc=%0d head=%h, expected full=1 dc=4 head=b001",
                  full, drop_count, out_data);
      end
      tick();
      ready = 1'b1;
      for (int i = 1; i < 17; i++) begin
         logic [15:0] exp_d;
         exp_d = (i == 16) ? 16'hC0DE : 16'hB000 + 16'(i);
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d) begin
            errors++;
            $display("FAIL fullpp_drain%0d: got v=%b d=%h, expected v=1 d=%h", i, out_valid, out_data, exp_d);
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fullpp_empty: got v=%b, expected 0", out_valid);
      end
      ready = 1'b0;
   endtask

   task automatic test_fin_level();
      rearm();
      data_miso = 16'h5555;
      fin = 1'b1;
      repeat (10) tick();
      fin = 1'b0;
      tick();
      checks++;
      if (sample_count !== 16'd1 || out_valid !== 1'b1 || out_data !== 16'h5555) begin
         errors++;
         $display("FAIL level_one: got sc=%0d v=%b d=%h, expected sc=1 v=1 d=5555", sample_count, out_valid, out_data);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL level_single: got v=%b, expected 0", out_valid);
      end
      on = 1'b0;
      for (int i = 0; i < 3; i++) pulse(16'h7700 + 16'(i));
      checks++;
      if (out_valid !== 1'b0 || sample_count !== 16'd0 || drop_count !== 8'd4) begin
         errors++;
         $display("FAIL off_ignored: got v=%b sc=%0d dc=%0d, expected v=0 sc=0 dc=4", out_valid, sample_count, drop_count);
      end
   endtask

   task automatic test_async_reset();
      ready = 1'b0;
      rearm();
      for (int i = 0; i < 5; i++) pulse(16'h6000 + 16'(i));
      checks++;
      if (out_valid !== 1'b1 || sample_count !== 16'd5) begin
         errors++;
         $display("FAIL arst_pre: got v=%b sc=%0d, expected v=1 sc=5", out_valid, sample_count);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sample_count !== 16'd0 || drop_count !== 8'd0 || full !== 1'b0 || out_data !== 16'h0) begin
         errors++;
         $display("FAIL arst_now: got v=%b sc=%0d dc=%0d f=%b d=%h, expected all zero",
                  out_valid, sample_count, drop_count, full, out_data);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_burst();
      test_full_push_pop();
      test_fin_level();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
